if_inst_buffer: RTL



---
 rtl/if_inst_buffer_if.sv | 31 +++
 rtl/if_inst_buffer.sv | 73 +++++++
 2 files changed

// File: rtl/if_inst_buffer_if.sv
// Purpose : IF->ID instruction-buffer handshake bundle (fetch side, decode side, flush inputs).
// Latency : n/a (wires only).
// Backpr. : ib_allowin throttles IF; id_allowin throttles the buffer head.
// Ports   : master = IF/ID/WB environment, slave = the buffer.
interface if_inst_buffer_if #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 97
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             if_id_valid;
   logic [WIDTH-1:0] if_id_bus;
   logic             ib_allowin;
   logic             ib_id_valid;
   logic [WIDTH-1:0] ib_id_bus;
   logic             id_allowin;
   logic             id_br_taken;
   logic             wb_ex;
   logic             ertn_flush;
   logic [CW-1:0]    ib_count;

   modport master (
      output if_id_valid, if_id_bus, id_allowin, id_br_taken, wb_ex, ertn_flush,
      input  ib_allowin, ib_id_valid, ib_id_bus, ib_count
   );

   modport slave (
      input  if_id_valid, if_id_bus, id_allowin, id_br_taken, wb_ex, ertn_flush,
      output ib_allowin, ib_id_valid, ib_id_bus, ib_count
   );
endinterface

// File: rtl/if_inst_buffer.sv
// Purpose : DEPTH-entry FIFO decoupling IF from ID; any flush drops every queued wrong-path entry.
// Latency : 1 cycle minimum (entry pushed at edge N is presented after edge N, no bypass).
// Backpr. : ib_allowin = not full (state only, no path from id_allowin); head held until id_allowin.
// Ports   : clk, resetn (async active-low); ib = slave side of if_inst_buffer_if
//           (IF push: if_id_valid/if_id_bus/ib_allowin, ID pop: ib_id_valid/ib_id_bus/id_allowin,
//            flushes: id_br_taken/wb_ex/ertn_flush, debug: ib_count).
module if_inst_buffer #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 97
) (
   input  logic              clk,
   input  logic              resetn,
   if_inst_buffer_if.slave   ib
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW:0]      count;

   logic flush;
   logic push;
   logic pop;
   logic not_empty;

   assign not_empty = (count != '0);
   assign flush     = ib.wb_ex | ib.ertn_flush | ib.id_br_taken;

   // Full is judged on stored state only, so a full buffer refuses a push
   // even when ID drains the head in the same cycle.
   assign ib.ib_allowin  = (count != CNT_FULL);
   // Head is hidden during a flush so ID never consumes a wrong-path entry.
   assign ib.ib_id_valid = not_empty & ~flush;
   assign ib.ib_id_bus   = not_empty ? mem[rd_ptr] : '0;
   assign ib.ib_count    = count;

   assign push = ib.if_id_valid & ib.ib_allowin & ~flush;
   assign pop  = ib.ib_id_valid & ib.id_allowin;

   // Payload storage carries no reset; occupancy gates everything visible.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= ib.if_id_bus;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule
